// File: rtl/rx_lector_d.sv
// Read-side merger: drains two FWFT destination FIFOs round-robin into one registered
// word stream, counting words per destination and flagging destination-bit mismatches.
module rx_lector_d #(
  parameter int unsigned DATA_W = 6,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              init,
  input  logic              empty_d0,
  input  logic              empty_d1,
  input  logic [DATA_W-1:0] data_d0,
  input  logic [DATA_W-1:0] data_d1,
  input  logic              pausa_rx,
  output logic              pop_d0,
  output logic              pop_d1,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              dest_out,
  output logic [CNT_W-1:0]  cnt_d0,
  output logic [CNT_W-1:0]  cnt_d1,
  output logic              active_out,
  output logic              idle_out,
  output logic              error_out
);

  localparam int unsigned DestBit = 4;

  typedef enum logic [1:0] {StInit, StIdle, StActive, StError} state_e;

  state_e            state;
  logic              rr_last;
  logic              elig0, elig1;
  logic              grant_any, grant_sel;
  logic [DATA_W-1:0] grant_word;
  logic              dest_bad;

  // Grant: D1 is selected when grant_sel=1; ties go to the FIFO not served last.
  always_comb begin
    elig0 = 1'b0;
    elig1 = 1'b0;
    if (state == StActive && !init && !pausa_rx) begin
      elig0 = !empty_d0;
      elig1 = !empty_d1;
    end
    grant_any  = elig0 | elig1;
    grant_sel  = (elig0 && elig1) ? ~rr_last : elig1;
    pop_d0     = grant_any & ~grant_sel;
    pop_d1     = grant_any & grant_sel;
    grant_word = grant_sel ? data_d1 : data_d0;
    dest_bad   = grant_word[DestBit] != grant_sel;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state     <= StInit;
      data_out  <= '0;
      valid_out <= 1'b0;
      dest_out  <= 1'b0;
      cnt_d0    <= '0;
      cnt_d1    <= '0;
      rr_last   <= 1'b1;
    end else if (init || state == StInit) begin
      state     <= init ? StInit : StIdle;
      data_out  <= '0;
      valid_out <= 1'b0;
      dest_out  <= 1'b0;
      cnt_d0    <= '0;
      cnt_d1    <= '0;
      rr_last   <= 1'b1;
    end else begin
      unique case (state)
        StIdle: begin
          valid_out <= 1'b0;
          if (!empty_d0 || !empty_d1) state <= StActive;
        end
        StActive: begin
          valid_out <= grant_any;
          if (grant_any) begin
            data_out <= grant_word;
            dest_out <= grant_sel;
            rr_last  <= grant_sel;
            if (grant_sel) cnt_d1 <= cnt_d1 + CNT_W'(1);
            else           cnt_d0 <= cnt_d0 + CNT_W'(1);
            // A mis-routed word is still delivered and counted before stopping.
            if (dest_bad) state <= StError;
          end else if (empty_d0 && empty_d1) begin
            state <= StIdle;
          end
        end
        StError: valid_out <= 1'b0;
        default: state <= StInit;
      endcase
    end
  end

  assign active_out = (state == StActive);
  assign idle_out   = (state == StIdle);
  assign error_out  = (state == StError);

endmodule

// File: tb/tb_rx_lector_d.sv
// Directed bench for rx_lector_d: two FWFT FIFO models feed a default instance and a
// 2-bit-counter instance in lockstep.
module tb_rx_lector_d;

  logic       clk = 1'b0;
  logic       reset_L, init, pausa_rx;
  logic       empty_d0, empty_d1;
  logic [5:0] data_d0, data_d1;
  logic       pop_d0, pop_d1, valid_out, dest_out, active_out, idle_out, error_out;
  logic [5:0] data_out;
  logic [7:0] cnt_d0, cnt_d1;
  logic       w2_pop_d0, w2_pop_d1, w2_valid, w2_dest, w2_active, w2_idle, w2_error;
  logic [5:0] w2_data;
  logic [1:0] w2_cnt_d0, w2_cnt_d1;

  int n_checks = 0;
  int n_errors = 0;

  logic [5:0] mem0 [64];
  logic [5:0] mem1 [64];
  int rd0 = 0, wr0 = 0, rd1 = 0, wr1 = 0;

  always #5 clk = ~clk;

  assign empty_d0 = (rd0 == wr0);
  assign empty_d1 = (rd1 == wr1);
  assign data_d0  = mem0[rd0];
  assign data_d1  = mem1[rd1];

  always @(posedge clk) begin
    if (pop_d0) rd0 <= rd0 + 1;
    if (pop_d1) rd1 <= rd1 + 1;
  end

  rx_lector_d dut (
    .clk(clk), .reset_L(reset_L), .init(init), .empty_d0(empty_d0), .empty_d1(empty_d1),
    .data_d0(data_d0), .data_d1(data_d1), .pausa_rx(pausa_rx), .pop_d0(pop_d0),
    .pop_d1(pop_d1), .data_out(data_out), .valid_out(valid_out), .dest_out(dest_out),
    .cnt_d0(cnt_d0), .cnt_d1(cnt_d1), .active_out(active_out), .idle_out(idle_out),
    .error_out(error_out)
  );

  rx_lector_d #(.DATA_W(6), .CNT_W(2)) dut_w2 (
    .clk(clk), .reset_L(reset_L), .init(init), .empty_d0(empty_d0), .empty_d1(empty_d1),
    .data_d0(data_d0), .data_d1(data_d1), .pausa_rx(pausa_rx), .pop_d0(w2_pop_d0),
    .pop_d1(w2_pop_d1), .data_out(w2_data), .valid_out(w2_valid), .dest_out(w2_dest),
    .cnt_d0(w2_cnt_d0), .cnt_d1(w2_cnt_d1), .active_out(w2_active), .idle_out(w2_idle),
    .error_out(w2_error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push0(input logic [5:0] w);
    mem0[wr0] = w;
    wr0++;
  endtask

  task automatic push1(input logic [5:0] w);
    mem1[wr1] = w;
    wr1++;
  endtask

  task automatic do_init();
    init = 1'b1;
    tick();
    init = 1'b0;
    tick();
  endtask

  initial begin
    logic [5:0] exp_data [4];
    logic       exp_dest [4];
    logic [1:0] exp_w2 [5];
    for (int i = 0; i < 64; i++) begin
      mem0[i] = '0;
      mem1[i] = '0;
    end
    reset_L  = 1'b0;
    init     = 1'b0;
    pausa_rx = 1'b0;
    tick();
    chk("rst_data", 32'(data_out), 32'h0);
    chk("rst_valid", 32'(valid_out), 32'h0);
    chk("rst_cnt", 32'({cnt_d1, cnt_d0}), 32'h0);
    chk("rst_state", 32'({active_out, idle_out, error_out}), 32'h0);
    reset_L = 1'b1;
    tick();

    // 1: init pulse with both FIFOs empty
    do_init();
    chk("t1_idle", 32'(idle_out), 32'h1);
    chk("t1_pops", 32'({pop_d1, pop_d0}), 32'h0);
    chk("t1_cnt", 32'({cnt_d1, cnt_d0}), 32'h0);

    // 2: two D0 words, D1 empty
    push0(6'h0B);
    push0(6'h03);
    chk("t2_idle_nopop", 32'(pop_d0), 32'h0);
    tick();
    chk("t2_active", 32'(active_out), 32'h1);
    chk("t2_pop_a", 32'(pop_d0), 32'h1);
    tick();
    chk("t2_data_a", 32'(data_out), 32'h0B);
    chk("t2_valid_a", 32'(valid_out), 32'h1);
    chk("t2_cnt_a", 32'(cnt_d0), 32'h1);
    chk("t2_pop_b", 32'(pop_d0), 32'h1);
    tick();
    chk("t2_data_b", 32'(data_out), 32'h03);
    chk("t2_cnt_b", 32'(cnt_d0), 32'h2);
    chk("t2_pop_none", 32'(pop_d0), 32'h0);
    tick();
    chk("t2_back_idle", 32'(idle_out), 32'h1);
    chk("t2_valid_low", 32'(valid_out), 32'h0);
    chk("t2_data_hold", 32'(data_out), 32'h03);

    // 3: round-robin with both FIFOs loaded
    do_init();
    push0(6'h03);
    push0(6'h09);
    push1(6'h1D);
    push1(6'h3B);
    exp_data = '{6'h03, 6'h1D, 6'h09, 6'h3B};
    exp_dest = '{1'b0, 1'b1, 1'b0, 1'b1};
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3_data", 32'(data_out), 32'(exp_data[i]));
      chk("t3_dest", 32'(dest_out), 32'(exp_dest[i]));
      chk("t3_valid", 32'(valid_out), 32'h1);
    end
    chk("t3_cnt", 32'({cnt_d1, cnt_d0}), 32'h0202);
    tick();
    chk("t3_idle", 32'(idle_out), 32'h1);

    // 4: pause holds off pops while staying active
    pausa_rx = 1'b1;
    push1(6'h15);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("t4_nopop", 32'(pop_d1), 32'h0);
      chk("t4_active", 32'(active_out), 32'h1);
      tick();
      chk("t4_valid_low", 32'(valid_out), 32'h0);
    end
    pausa_rx = 1'b0;
    #1;
    chk("t4_pop", 32'(pop_d1), 32'h1);
    tick();
    chk("t4_data", 32'(data_out), 32'h15);
    chk("t4_dest", 32'(dest_out), 32'h1);
    chk("t4_cnt_d1", 32'(cnt_d1), 32'h3);
    tick();

    // 5: destination mismatch on D0
    do_init();
    push0(6'h1B);
    push0(6'h02);
    tick();
    chk("t5_pop", 32'(pop_d0), 32'h1);
    tick();
    chk("t5_data", 32'(data_out), 32'h1B);
    chk("t5_cnt", 32'(cnt_d0), 32'h1);
    chk("t5_error", 32'(error_out), 32'h1);
    chk("t5_nopop", 32'(pop_d0), 32'h0);
    tick();
    chk("t5_valid_low", 32'(valid_out), 32'h0);
    chk("t5_frozen", 32'(cnt_d0), 32'h1);
    init = 1'b1;
    #1;
    chk("t5_init_nopop", 32'(pop_d0), 32'h0);
    tick();
    chk("t5_cnt_clr", 32'(cnt_d0), 32'h0);
    chk("t5_err_clr", 32'(error_out), 32'h0);
    init = 1'b0;
    tick();
    tick();
    tick();
    chk("t5_drain", 32'(data_out), 32'h02);
    tick();

    // 6: counter wrap on the 2-bit instance, then reset mid-stream
    do_init();
    for (int i = 1; i <= 7; i++) push0(6'(i));
    exp_w2 = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t6_w2_cnt", 32'(w2_cnt_d0), 32'(exp_w2[i]));
      chk("t6_cnt", 32'(cnt_d0), 32'(i + 1));
    end
    chk("t6_pop_before", 32'(pop_d0), 32'h1);
    #2;
    reset_L = 1'b0;
    #1;
    chk("t6_rst_pop", 32'({w2_pop_d0, pop_d0}), 32'h0);
    chk("t6_rst_data", 32'({valid_out, dest_out, data_out}), 32'h0);
    chk("t6_rst_cnt", 32'({w2_cnt_d0, cnt_d0}), 32'h0);
    chk("t6_rst_state", 32'({active_out, idle_out, error_out}), 32'h0);
    tick();
    reset_L = 1'b1;
    #1;
    chk("t6_rel_pop", 32'(pop_d0), 32'h0);
    tick();
    chk("t6_rel_idle", 32'(idle_out), 32'h1);
    chk("t6_idle_nopop", 32'(pop_d0), 32'h0);
    tick();
    chk("t6_resume_pop", 32'(pop_d0), 32'h1);
    tick();
    chk("t6_resume_data", 32'(data_out), 32'h06);
    chk("t6_resume_w2", 32'(w2_cnt_d0), 32'h1);
    tick();
    chk("t6_last_data", 32'(data_out), 32'h07);
    tick();
    chk("t6_end_idle", 32'(idle_out), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rx_lector_d.md
Name: rx_lector_d

Overview:
- Read-side end of the transaction-layer datapath: drains the two destination FIFOs (D0, D1) and merges them into one registered 6-bit output stream.
- Both FIFOs are first-word-fall-through: the head word is valid whenever empty_dX=0, and a pop advances the FIFO at the clock edge.
- Arbitrates round-robin between D0 and D1, honours a downstream pause, counts words per destination, and checks destination-bit consistency.
- Reports idle/active/error status alongside the rest of the condition logic.

Parameters:
DATA_W, 6, word width; bit[5]=VC, bit[4]=destination, bits[3:0]=payload
CNT_W, 8, width of per-destination word counters

Ports:
clk  input  1  system clock, rising edge
reset_L  input  1  asynchronous active-low reset
init  input  1  synchronous re-initialise request, level
empty_d0  input  1  D0 FIFO empty
empty_d1  input  1  D1 FIFO empty
data_d0  input  DATA_W  D0 FIFO head word (FWFT)
data_d1  input  DATA_W  D1 FIFO head word (FWFT)
pausa_rx  input  1  downstream pause; no pops while high
pop_d0  output  1  pop D0 (combinational)
pop_d1  output  1  pop D1 (combinational)
data_out  output  DATA_W  registered merged word
valid_out  output  1  data_out valid this cycle
dest_out  output  1  source FIFO of data_out (0=D0, 1=D1)
cnt_d0  output  CNT_W  words delivered from D0
cnt_d1  output  CNT_W  words delivered from D1
active_out  output  1  state==ACTIVE
idle_out  output  1  state==IDLE
error_out  output  1  state==ERROR

Behaviour:
- Interface decision: one clock (clk); reset (reset_L) is asynchronous and active-low.
- Reset (reset_L=0, asynchronous):
  - state=INIT.
  - data_out=0, valid_out=0, dest_out=0, cnt_d0=0, cnt_d1=0, rr_last=1 (so D0 wins first).
  - pop_d0/pop_d1=0 while in reset.
- States: INIT, IDLE, ACTIVE, ERROR.
- Transition priority: reset > init > all other transitions.
- init=1 in any state → next state INIT.
- INIT:
  - Clears counters, data_out, valid_out, dest_out; sets rr_last=1; no pops.
  - Exit to IDLE on the first cycle with init=0.
- IDLE:
  - No pops.
  - → ACTIVE when empty_d0=0 or empty_d1=0, regardless of pausa_rx.
- ACTIVE, eligibility: pops allowed only when pausa_rx=0; D0 eligible = !empty_d0, D1 eligible = !empty_d1.
- ACTIVE, grant:
  - Both eligible → grant the FIFO opposite rr_last.
  - One eligible → grant that FIFO.
  - At most one pop per cycle.
  - pop_dX is combinational, asserted in the same cycle as the grant.
- Capture on a granted edge:
  - data_out ← granted head word; dest_out ← grant; valid_out ← 1; rr_last ← grant.
  - cnt_dX increments, wrapping at 2^CNT_W−1 → 0.
- Latency: word popped in cycle N appears on data_out with valid_out=1 in cycle N+1.
- No grant in a cycle → valid_out=0 next cycle; data_out and dest_out hold their previous values.
- ACTIVE → IDLE when empty_d0=empty_d1=1 and no pop occurs this cycle.
- A pause alone never leaves ACTIVE.
- Destination check, applied on every granted word:
  - Word popped from D0 must have bit[4]=0; word from D1 must have bit[4]=1.
  - On mismatch: the word is still delivered and counted, and next state is ERROR.
- ERROR:
  - No pops; valid_out=0 from the cycle after entry.
  - Counters frozen.
  - Exit only via init=1 (→ INIT) or reset.
- Simultaneous events:
  - init=1 with a non-empty FIFO: no pop, go to INIT.
  - pausa_rx rising in the same cycle as eligibility: no pop that cycle.
- Reset asserted mid-transfer: a word popped in that cycle is not captured; the FIFO side owns recovery.

Test Plan:
1. Reset 1 cycle, init 1 cycle, both FIFOs empty → INIT then IDLE, idle_out=1, pop_d0=pop_d1=0, counters 0.
2. D0 holds 0x0B,0x03 (bit4=0), D1 empty → pops on 2 consecutive cycles; data_out=0x0B then 0x03, each 1 cycle after its pop; cnt_d0=2; returns to IDLE.
3. D0 holds 0x03,0x09, D1 holds 0x1D,0x3B → output order 0x03,0x1D,0x09,0x3B; dest_out=0,1,0,1; cnt_d0=cnt_d1=2.
4. D1 non-empty, pausa_rx=1 for 3 cycles → no pop and valid_out=0 for those 3 cycles while staying ACTIVE; first pop in the cycle pausa_rx falls.
5. D0 head 0x1B (bit4=1) → word delivered, cnt_d0=1, then ERROR with error_out=1 and no further pops; init=1 → INIT, counters 0, error_out=0.
6. CNT_W=2 and 5 D0 words → cnt_d0 sequence 1,2,3,0,1; assert reset_L=0 mid-stream → all outputs 0 immediately, no glitch on pop_d0 after release.
